// File: rtl/conv1_b_tile_feeder.sv
// conv1_b_tile_feeder
//   Feeds one weight tile from B_buf into the top edge of a COLS-wide
//   systolic array. Rows are issued one per advance cycle. Column c sees
//   each row after 1+c advance cycles (output register plus c skew stages).
//   After the last row, COLS drain cycles flush the skew. A one-cycle done
//   pulse then returns the block to idle.
//
//   Optional feature: define CONV1_BF_KPAD_EN to always feed K_TILE rows.
//   Rows beyond the loaded k are issued as zero data, but still flagged
//   valid on active columns.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : tile-feed request pulse (honoured only when idle)
//   adv          : array advance enable; FSM and skew move only when high
//   k_eff, n_eff : valid row / column count of the loaded tile
//   B_buf        : loaded weight tile, held stable while busy
//   busy, done   : feeding-or-draining flag, one-cycle completion pulse
//   b_out        : per-column weight into the array
//   b_valid      : per-column valid flag
//   b_last       : per-column last-row flag
module conv1_b_tile_feeder #(
  parameter int COLS     = 16,
  parameter int K_MAX    = 2048,
  parameter int K_TILE   = 16,
  parameter int DATA_W_P = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       adv,
  input  int                         k_eff,
  input  int                         n_eff,
  input  logic signed [DATA_W_P-1:0] B_buf [K_MAX][COLS],
  output logic                       busy,
  output logic                       done,
  output logic signed [DATA_W_P-1:0] b_out [COLS],
  output logic [COLS-1:0]            b_valid,
  output logic [COLS-1:0]            b_last
);

  localparam int CNT_MAX = (K_TILE > COLS) ? K_TILE : COLS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int N_W     = $clog2(COLS + 1);
  localparam int RA_W    = (K_MAX > 1) ? $clog2(K_MAX) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [CNT_W-1:0]           k_lat, k_clamp, rows_req, rows_total;
  logic [N_W-1:0]             n_lat, n_clamp;
  logic                       issue;
  logic [RA_W-1:0]            row_idx;
  logic signed [DATA_W_P-1:0] din [COLS];
  logic [COLS-1:0]            vin, lin;

  always_comb begin
    if (k_eff < 0)           k_clamp = '0;
    else if (k_eff > K_TILE) k_clamp = CNT_W'(K_TILE);
    else                     k_clamp = CNT_W'(k_eff);
    if (n_eff < 0)           n_clamp = '0;
    else if (n_eff > COLS)   n_clamp = N_W'(COLS);
    else                     n_clamp = N_W'(n_eff);
  end

`ifdef CONV1_BF_KPAD_EN
  assign rows_req   = CNT_W'(K_TILE);
  assign rows_total = CNT_W'(K_TILE);
`else
  assign rows_req   = k_clamp;
  assign rows_total = k_lat;
`endif

  // Control: state, row/drain counter, latched tile geometry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      k_lat <= '0;
      n_lat <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && start) begin
        k_lat <= k_clamp;
        n_lat <= n_clamp;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt   = '0;
          state_nxt = (rows_req == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (adv) begin
          issue = 1'b1;
          if (cnt == rows_total - CNT_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (adv) begin
          if (cnt == CNT_W'(COLS - 1)) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == FEED) || (state == DRAIN);
  assign done    = (state == DONE);
  assign row_idx = RA_W'(cnt);

  // Issue: B_buf is sampled only on an issuing cycle; padded rows carry zero data
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      din[c] = '0;
      vin[c] = 1'b0;
      lin[c] = 1'b0;
      if (issue && (c < int'(n_lat))) begin
        vin[c] = 1'b1;
        lin[c] = (cnt == rows_total - CNT_W'(1));
        if (cnt < k_lat) din[c] = B_buf[row_idx][c];
      end
    end
  end

  // Skew: column c owns c+1 stages, the last of which drives the outputs
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic signed [DATA_W_P-1:0] sr [c+1];
    logic [c:0]                 vsr, lsr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= c; d++) sr[d] <= '0;
        vsr <= '0;
        lsr <= '0;
      end else if (adv) begin
        sr[0]  <= din[c];
        vsr[0] <= vin[c];
        lsr[0] <= lin[c];
        for (int d = 1; d <= c; d++) begin
          sr[d]  <= sr[d-1];
          vsr[d] <= vsr[d-1];
          lsr[d] <= lsr[d-1];
        end
      end
    end

    assign b_out[c]   = sr[c];
    assign b_valid[c] = vsr[c];
    assign b_last[c]  = lsr[c];
  end

endmodule

// File: tb/tb_conv1_b_tile_feeder.sv
// Testbench for conv1_b_tile_feeder. The reference model tracks, per tile,
// how many advance edges have passed since FEED entry. From that count
// alone it predicts which row every column must show, together with busy
// and done.
module tb_conv1_b_tile_feeder;
  localparam int COLS   = 16;
  localparam int K_MAX  = 2048;
  localparam int K_TILE = 16;
  localparam int DW     = 16;

  logic                 clk = 1'b0;
  logic                 rst_n, start, adv;
  int                   k_eff, n_eff;
  logic signed [DW-1:0] B_buf [K_MAX][COLS];
  logic                 busy, done;
  logic signed [DW-1:0] b_out [COLS];
  logic [COLS-1:0]      b_valid, b_last;

  conv1_b_tile_feeder #(.COLS(COLS), .K_MAX(K_MAX), .K_TILE(K_TILE), .DATA_W_P(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .adv(adv), .k_eff(k_eff), .n_eff(n_eff),
    .B_buf(B_buf), .busy(busy), .done(done), .b_out(b_out), .b_valid(b_valid), .b_last(b_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  bit m_active, m_done_now;
  int m_a, m_k, m_n, m_rows;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_active = 0; m_done_now = 0; m_a = 100000; m_k = 0; m_n = 0; m_rows = 0;
  endtask

  task automatic model_edge();
    bit starting;
    starting = !m_active && !m_done_now && start;
    if (adv && !starting && m_a < 100000) m_a++;
    if (m_done_now) m_done_now = 0;
    else if (starting) begin
      m_k = clampi(k_eff, K_TILE);
      m_n = clampi(n_eff, COLS);
`ifdef CONV1_BF_KPAD_EN
      m_rows = K_TILE;
`else
      m_rows = m_k;
`endif
      m_a = 0;
      if (m_rows == 0) m_done_now = 1;
      else m_active = 1;
    end else if (m_active && adv && m_a == m_rows + COLS) begin
      m_active = 0;
      m_done_now = 1;
    end
  endtask

  task automatic check_outputs();
    int r;
    bit v;
    longint d;
    chk("busy", busy, m_active);
    chk("done", done, m_done_now);
    for (int c = 0; c < COLS; c++) begin
      r = m_a - 1 - c;
      v = (r >= 0) && (r < m_rows) && (c < m_n);
      d = (v && r < m_k) ? longint'(B_buf[r][c]) : 0;
      chk($sformatf("b_out[%0d]", c), b_out[c], d);
      chk($sformatf("b_valid[%0d]", c), b_valid[c], v);
      chk($sformatf("b_last[%0d]", c), b_last[c], v && (r == m_rows - 1));
    end
  endtask

  // Called at #1 after a rising edge; applies inputs for the next edge.
  task automatic cycle(input logic a, input logic s);
    adv = a;
    start = s;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic fill(input bit pattern);
    for (int r = 0; r < K_TILE; r++)
      for (int c = 0; c < COLS; c++)
        B_buf[r][c] = pattern ? DW'(16 * r + c) : DW'($urandom);
  endtask

  // mode 0: adv always 1; 1: random adv; 2: adv pattern 1,0,0,1
  task automatic run_tile(input int k, input int n, input int mode, input bit refill, input bit pat);
    bit a, s;
    k_eff = k;
    n_eff = n;
    if (refill) fill(pat);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 400 && (m_active || m_done_now); i++) begin
      a = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : ((i % 4 == 0) || (i % 4 == 3));
      s = (mode != 0) && ($urandom_range(0, 3) == 0);
      if (mode != 0) begin
        k_eff = $urandom_range(0, 40) - 5;
        n_eff = $urandom_range(0, 40) - 5;
      end
      cycle(a, s);
    end
    chk("tile_finished", m_active || m_done_now, 0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  task automatic reset_mid_feed();
    k_eff = 16;
    n_eff = 16;
    fill(1'b0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    for (int c = 0; c < COLS; c++) begin
      chk($sformatf("rst_b_out[%0d]", c), b_out[c], 0);
      chk($sformatf("rst_b_valid[%0d]", c), b_valid[c], 0);
      chk($sformatf("rst_b_last[%0d]", c), b_last[c], 0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    run_tile(16, 16, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; adv = 1'b0; k_eff = 0; n_eff = 0;
    for (int r = 0; r < K_MAX; r++)
      for (int c = 0; c < COLS; c++) B_buf[r][c] = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    cycle(1'b1, 1'b0);

    run_tile(16, 16, 0, 1'b1, 1'b1);
    run_tile(3, 16, 0, 1'b1, 1'b0);
    run_tile(16, 4, 0, 1'b1, 1'b1);
    run_tile(0, 16, 0, 1'b1, 1'b0);
    run_tile(0, 5, 0, 1'b1, 1'b0);
    run_tile(-5, 7, 0, 1'b1, 1'b0);
    run_tile(40, 99, 0, 1'b1, 1'b0);
    run_tile(16, 16, 2, 1'b1, 1'b1);
    reset_mid_feed();
    for (int t = 0; t < 20; t++)
      run_tile($urandom_range(0, 24) - 2, $urandom_range(0, 20) - 2, 1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout obs=%0d exp=%0d", 1, 0);
    $fatal(1);
  end
endmodule

// File: doc/conv1_b_tile_feeder.md
CONV1_B_TILE_FEEDER -- requirements
Module: conv1_b_tile_feeder

Interface
- REQ-001: Parameter COLS, default 16, SHALL set the systolic array column count and the B_buf width.
- REQ-002: Parameter K_MAX, default 2048, SHALL set the B_buf row depth.
- REQ-003: Parameter K_TILE, default 16, SHALL set the maximum rows fed per tile.
- REQ-004: Parameter DATA_W_P, default DATA_W from backbone_pkg, SHALL set the signed element width.
- REQ-005: Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
- REQ-006: Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
- REQ-007: Port start, input, 1 bit, SHALL be the tile-feed request pulse.
- REQ-008: Port adv, input, 1 bit, SHALL be the array advance enable; the feeder and skew pipeline SHALL move only when adv=1.
- REQ-009: Port k_eff, input, int, SHALL give the valid row count of the loaded tile.
- REQ-010: Port n_eff, input, int, SHALL give the valid column count of the loaded tile.
- REQ-011: Port B_buf, input, signed [DATA_W_P-1:0] [K_MAX][COLS], SHALL be the loaded weight tile.
- REQ-012: Port busy, output, 1 bit, SHALL be high in FEED and DRAIN.
- REQ-013: Port done, output, 1 bit, SHALL pulse for one cycle when the tile is fully flushed.
- REQ-014: Port b_out, output, signed [DATA_W_P-1:0] [COLS], SHALL carry the per-column weight into the array top edge.
- REQ-015: Port b_valid, output, COLS bits, SHALL flag valid b_out per column.
- REQ-016: Port b_last, output, COLS bits, SHALL flag the last valid row per column.

Function
- REQ-017: The FSM SHALL have states IDLE, FEED, DRAIN and DONE.
- REQ-018: In IDLE, start=1 SHALL latch k_eff and n_eff, clamped to [0,K_TILE] and [0,COLS], and SHALL enter FEED next cycle.
- REQ-019: When the clamped row count is 0, start SHALL go IDLE->DONE directly.
- REQ-020: In FEED, each adv=1 cycle SHALL issue row r, with r running 0..k-1, from B_buf[r][0..COLS-1] into the skew pipeline; after row k-1 the FSM SHALL enter DRAIN.
- REQ-021: Column c SHALL present row r on b_out[c] exactly 1+c adv-cycles after row r issues (registered output plus c skew stages).
- REQ-022: b_valid[c] SHALL be 1 only for issued rows with c < n; columns c >= n SHALL drive b_out=0 and b_valid=0.
- REQ-023: b_last[c] SHALL be 1 together with b_valid[c] for row k-1 only.
- REQ-024: DRAIN SHALL last COLS adv-cycles (zeros/invalid injected) and SHALL then enter DONE.
- REQ-025: DONE SHALL assert done for one cycle, independent of adv, and SHALL return to IDLE.
- REQ-026: adv=0 SHALL freeze the FSM, the row counter, the skew pipeline and all b_* outputs.
- REQ-027: start outside IDLE SHALL be ignored.
- REQ-028: B_buf SHALL be read only at row issue and SHALL be held stable by the producer while busy=1.

Reset
- REQ-029: rst_n=0 SHALL force IDLE, clear the row counter and skew pipeline, and drive busy=0, done=0, b_out=0, b_valid=0, b_last=0, regardless of the current state (including mid-FEED or mid-DRAIN).
- REQ-030: After reset release, the first accepted start SHALL behave as in REQ-018.

Configuration
- REQ-031: With macro CONV1_BF_KPAD_EN defined, the row count SHALL always be K_TILE. Rows k..K_TILE-1 SHALL issue as zero data with b_valid=1 for c<n, and b_last SHALL mark row K_TILE-1. The row count 0 case SHALL then also feed K_TILE zero rows.
- REQ-032: Without CONV1_BF_KPAD_EN, the row count SHALL be the clamped k_eff per REQ-018..REQ-023.

Verification
- REQ-033: COLS=16, k=16, n=16, B_buf[r][c]=16r+c, adv=1 -> b_out[c]=16r+c appears at cycle r+1+c after FEED entry; done 1 cycle after 32 advance cycles.
- REQ-034: k=3 (tail tile), n=16, adv=1 -> b_last[5] high with b_out[5]=B_buf[2][5] at relative cycle 8; DRAIN=16 cycles; done pulses once.
- REQ-035: k=16, n=4 -> b_valid[15:4]=0 and b_out[15:4]=0 throughout; columns 0..3 match REQ-033 timing.
- REQ-036: adv toggling 1,0,0,1 during FEED -> outputs hold over the 2 low cycles; whole timeline shifts exactly 2 cycles; start asserted mid-FEED has no effect.
- REQ-037: k_eff=0 -> done 1 cycle after start with no valid beats; with CONV1_BF_KPAD_EN -> 16 zero rows with b_valid=1 on columns < n.
- REQ-038: rst_n=0 at row 7 of FEED -> all outputs 0 asynchronously, state IDLE; next start replays the tile from row 0.
